// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle barrel shifter/rotator, one power-of-two stage per cycle
module shift_seq_ctrl #(
   parameter int EARLY_EXIT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [15:0] in_a,
   input  logic [3:0]  in_amt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
   output logic        out_err,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam logic [3:0] OP_RLL = 4'b0000;
   localparam logic [3:0] OP_SLL = 4'b0001;
   localparam logic [3:0] OP_SRA = 4'b0010;
   localparam logic [3:0] OP_SRL = 4'b0011;
   localparam logic [3:0] OP_RRL = 4'b1010;

   state_t      r_state, w_next_state;
   logic [15:0] r_work;
   logic [3:0]  r_op;
   logic [3:0]  r_amt;
   logic [1:0]  r_stage;
   logic        r_err;

   logic        w_sup_in;
   logic        w_zero_stages;
   logic [3:0]  w_rem;
   logic        w_last;
   logic [1:0]  w_next_stage;
   logic        w_do_stage;

   function automatic logic is_supported(input logic [3:0] op);
      return (op == OP_RLL) || (op == OP_SLL) || (op == OP_SRA) ||
             (op == OP_SRL) || (op == OP_RRL);
   endfunction

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [1:0] lowest_set(input logic [3:0] mask);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic logic [15:0] apply_stage(input logic [3:0] op, input logic [15:0] val,
                                               input logic [1:0] k);
      logic [4:0] s;
      s = 5'd1 << k;
      case (op)
         OP_RLL:  return (val << s) | (val >> (5'd16 - s));
         OP_SLL:  return val << s;
         OP_SRA:  return $signed(val) >>> s;
         OP_SRL:  return val >> s;
         OP_RRL:  return (val >> s) | (val << (5'd16 - s));
         default: return val;
      endcase
   endfunction

   assign w_sup_in      = is_supported(in_op);
   assign w_zero_stages = !w_sup_in || ((EARLY_EXIT != 0) && (in_amt == 4'd0));
   // Amount bits strictly above the current stage decide whether another stage remains.
   assign w_rem         = r_amt & (4'b1110 << r_stage);
   assign w_last        = (EARLY_EXIT != 0) ? (w_rem == 4'd0) : (r_stage == 2'd3);
   assign w_next_stage  = (EARLY_EXIT != 0) ? lowest_set(w_rem) : r_stage + 2'd1;
   assign w_do_stage    = (EARLY_EXIT != 0) || r_amt[r_stage];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next_state = w_zero_stages ? S_DONE : S_SHIFT;
         S_SHIFT: if (w_last) w_next_state = S_DONE;
         S_DONE:  if (out_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = (r_state == S_IDLE);
      out_valid  = (r_state == S_DONE);
      busy       = (r_state != S_IDLE);
      out_err    = (r_state == S_DONE) && r_err;
      out_result = r_work;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work  <= 16'h0000;
         r_op    <= 4'd0;
         r_amt   <= 4'd0;
         r_stage <= 2'd0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_work  <= in_a;
                  r_op    <= in_op;
                  r_amt   <= in_amt;
                  r_err   <= !w_sup_in;
                  r_stage <= (EARLY_EXIT != 0) ? lowest_set(in_amt) : 2'd0;
               end
            end
            S_SHIFT: begin
               if (w_do_stage) r_work <= apply_stage(r_op, r_work, r_stage);
               r_stage <= w_last ? 2'd0 : w_next_stage;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed scoreboard bench for shift_seq_ctrl (EARLY_EXIT 1 and 0)
module tb_shift_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_op;
   logic [15:0] in_a;
   logic [3:0]  in_amt;
   logic        in_valid0, in_valid1, out_ready0, out_ready1;
   logic        in_ready0, in_ready1, out_valid0, out_valid1;
   logic        out_err0, out_err1, busy0, busy1;
   logic [15:0] out_result0, out_result1;

   typedef struct {
      logic [15:0] res;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_fail = 0;
   bit   cur = 1'b0;

   logic        o_ready, o_valid, o_err, o_busy;
   logic [15:0] o_res;
   assign o_ready = cur ? in_ready1   : in_ready0;
   assign o_valid = cur ? out_valid1  : out_valid0;
   assign o_err   = cur ? out_err1    : out_err0;
   assign o_busy  = cur ? busy1       : busy0;
   assign o_res   = cur ? out_result1 : out_result0;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.EARLY_EXIT(1)) u_ee1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_op(in_op), .in_a(in_a), .in_amt(in_amt), .out_valid(out_valid0),
      .out_ready(out_ready0), .out_result(out_result0), .out_err(out_err0), .busy(busy0));

   shift_seq_ctrl #(.EARLY_EXIT(0)) u_ee0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_op(in_op), .in_a(in_a), .in_amt(in_amt), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_result(out_result1), .out_err(out_err1), .busy(busy1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_res(input logic [3:0] op, input logic [15:0] a,
                                           input logic [3:0] amt);
      logic [31:0]        t;
      logic signed [15:0] sa;
      int                 n;
      n  = int'(amt);
      sa = a;
      case (op)
         4'b0000: begin t = {a, a} << n; return t[31:16]; end
         4'b0001: return a << n;
         4'b0010: return sa >>> n;
         4'b0011: return a >> n;
         4'b1010: begin t = {a, a} >> n; return t[15:0]; end
         default: return a;
      endcase
   endfunction

   function automatic bit ref_sup(input logic [3:0] op);
      return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1010};
   endfunction

   task automatic run(input bit sel, input logic [3:0] op, input logic [15:0] a,
                      input logic [3:0] amt, input int hold);
      exp_t e, got;
      int   lat;
      cur   = sel;
      e.res = ref_res(op, a, amt);
      e.err = !ref_sup(op);
      if (!ref_sup(op))   e.lat = 1;
      else if (sel == 0)  e.lat = $countones(amt) + 1;
      else                e.lat = 5;
      sb.push_back(e);
      check("ready_before", o_ready, 1);
      in_op = op; in_a = a; in_amt = amt;
      if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      in_op = 4'hF; in_a = 16'hDEAD; in_amt = 4'hF;
      lat = 1;
      while (!o_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      got = sb.pop_front();
      check("valid", o_valid, 1);
      check("latency", lat, got.lat);
      check("result", o_res, got.res);
      check("err", o_err, got.err);
      check("ready_done", o_ready, 0);
      check("busy_done", o_busy, 1);
      for (int i = 0; i < hold; i++) begin
         if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
         @(posedge clk); #1;
         check("hold_valid", o_valid, 1);
         check("hold_result", o_res, got.res);
         check("hold_err", o_err, got.err);
         check("hold_ready", o_ready, 0);
      end
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      if (sel) out_ready1 = 1'b1; else out_ready0 = 1'b1;
      @(posedge clk); #1;
      out_ready0 = 1'b0; out_ready1 = 1'b0;
      check("idle_valid", o_valid, 0);
      check("idle_ready", o_ready, 1);
      check("idle_busy", o_busy, 0);
   endtask

   initial begin
      logic [3:0] ops [5];
      int         seen;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1010};
      rst_n = 1'b0;
      in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready0 = 1'b0; out_ready1 = 1'b0;
      in_op = 4'd0; in_a = 16'd0; in_amt = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", in_ready0, 1);
      check("rst_valid", out_valid0, 0);
      check("rst_err", out_err0, 0);
      check("rst_busy", busy0, 0);
      check("rst_result", out_result0, 16'h0000);
      check("rst_result_ee0", out_result1, 16'h0000);
      rst_n = 1'b1;

      run(0, 4'b0001, 16'h0001, 4'd4, 0);
      run(0, 4'b0000, 16'h8001, 4'd1, 1);
      run(0, 4'b1010, 16'h0001, 4'd0, 0);
      run(0, 4'b0011, 16'h8000, 4'd15, 0);
      run(0, 4'b0100, 16'h1234, 4'd7, 2);
      run(0, 4'b0010, 16'h8000, 4'd5, 0);
      run(0, 4'b1010, 16'h1234, 4'd11, 0);
      for (int i = 0; i < 6; i++)
         run(0, ops[$urandom_range(0, 4)], 16'($urandom), 4'($urandom), $urandom_range(0, 2));

      run(1, 4'b0010, 16'h8000, 4'd15, 3);
      run(1, 4'b0001, 16'h00F0, 4'd0, 0);
      run(1, 4'b1010, 16'h0003, 4'd9, 0);
      run(1, 4'b0111, 16'hBEEF, 4'd3, 0);

      cur = 1'b0;
      in_op = 4'b0001; in_a = 16'h0001; in_amt = 4'd15; in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      @(posedge clk); #1;
      check("mid_busy", busy0, 1);
      rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid0, 0);
      check("arst_busy", busy0, 0);
      check("arst_ready", in_ready0, 1);
      check("arst_err", out_err0, 0);
      check("arst_result", out_result0, 16'h0000);
      #1 rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid0) seen++;
      end
      check("discarded", seen, 0);
      run(0, 4'b0001, 16'h0001, 4'd15, 0);
      check("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
